// File: rtl/tri_bus_receiver.sv
// Receiver end of the 4-bit strobed tri-state bus: nibble pairs -> bytes -> small FIFO.
// Define RX_TIMEOUT_EN to abandon a half-received byte after TIMEOUT idle cycles.
module tri_bus_receiver #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       bus_y,
  input  logic             bus_en,
  output logic             nibble_ack,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             timeout_err
);

  if ((1 << PTR_W) != DEPTH || DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1) begin : g_param_err
    $error("tri_bus_receiver: DEPTH must equal 2**PTR_W in 2..16 and TIMEOUT >= 1");
  end

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  typedef enum logic {ST_LOW, ST_HIGH} state_e;

  state_e           state_q, state_d;
  logic [3:0]       lo_q, lo_d;
  logic             en_q;
  logic             ack_q;
  logic             cap;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q;
  logic [7:0]       last_q;
  logic [7:0]       mem [DEPTH];

  assign cap = bus_en & ~en_q;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_fire;
  logic          terr_q;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    push_req = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo_d    = '0;
    tmo_fire = 1'b0;
`endif
    case (state_q)
      ST_LOW: begin
        if (cap) begin
          lo_d    = bus_y;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cap) begin
          push_req = 1'b1;
          state_d  = ST_LOW;
        end
`ifdef RX_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT)) begin
          tmo_fire = 1'b1;
          state_d  = ST_LOW;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = ST_LOW;
    endcase
  end

  // A pop in the same cycle frees the slot the push needs.
  assign full     = (count_q == DEPTH_C);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_en & rd_valid;
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LOW;
      lo_q     <= '0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      en_q    <= bus_en;
      ack_q   <= cap;
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; count/pointers guarantee no stale entry is ever presented.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {bus_y, lo_q};
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (tmo_fire) terr_q <= 1'b1;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign rd_data    = rd_valid ? mem[rd_ptr_q] : last_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign nibble_ack = ack_q;

endmodule

// File: tb/tb_tri_bus_receiver.sv
// Directed bench for tri_bus_receiver; expected bytes flow through a scoreboard queue.
module tb_tri_bus_receiver;

  localparam int DEPTH = 4;
`ifdef RX_TIMEOUT_EN
  localparam int HOLD_LONG = 10;
`else
  localparam int HOLD_LONG = 20;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] bus_y;
  logic       bus_en;
  logic       nibble_ack;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       overflow;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] mq[$];
  logic       exp_ovf;

  tri_bus_receiver #(.DEPTH(DEPTH), .PTR_W(2), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus_y       (bus_y),
    .bus_en      (bus_en),
    .nibble_ack  (nibble_ack),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    exp_ovf = 1'b0;
  endtask

  // Strobe one nibble for 'hold' cycles and count ack pulses until after release.
  task automatic send_nibble(input logic [3:0] n, input int hold);
    int acks;
    acks = 0;
    @(negedge clk);
    bus_y  = n;
    bus_en = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      acks += int'(nibble_ack);
    end
    bus_en = 1'b0;
    bus_y  = 4'hx;
    @(negedge clk);
    acks += int'(nibble_ack);
    check("ack_pulses", acks, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    send_nibble(b[3:0], hold);
    if (mq.size() < DEPTH) mq.push_back(b);
    else exp_ovf = 1'b1;
    send_nibble(b[7:4], hold);
    check("count_after_byte", count, mq.size());
  endtask

  task automatic pop_check();
    logic [7:0] exp_b;
    @(negedge clk);
    exp_b = (mq.size() != 0) ? mq.pop_front() : 8'hxx;
    check("pop_valid", rd_valid, 1);
    check("pop_data", rd_data, exp_b);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_count", count, mq.size());
  endtask

  initial begin
    reset_n = 1'b0;
    bus_y   = 4'h0;
    bus_en  = 1'b0;
    rd_en   = 1'b0;
    exp_ovf = 1'b0;
    tick(2);
    reset_n = 1'b1;

    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_ack", nibble_ack, 0);
    check("rst_ovf", overflow, 0);
    check("rst_terr", timeout_err, 0);

    // Basic pair, long strobes.
    send_byte(8'h5A, 5);
    check("basic_valid", rd_valid, 1);
    check("basic_data", rd_data, 8'h5A);
    pop_check();
    check("basic_empty", rd_valid, 0);
    check("hold_last", rd_data, 8'h5A);

    // One capture for a long strobe; the next nibble then completes the byte.
    send_nibble(4'h3, HOLD_LONG);
    check("long_count", count, 0);
    mq.push_back(8'h43);
    send_nibble(4'h4, 1);
    check("long_state_high", count, 1);
    pop_check();

    // Overflow: five bytes into a four-deep FIFO.
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1);
    check("ovf_count", count, DEPTH);
    check("ovf_flag", overflow, exp_ovf);
    for (int i = 0; i < DEPTH; i++) pop_check();
    check("ovf_drained", rd_valid, 0);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 1);
    send_nibble(4'h4, 1);
    @(negedge clk);
    check("sim_head", rd_data, mq[0]);
    void'(mq.pop_front());
    mq.push_back(8'h24);
    bus_y  = 4'h2;
    bus_en = 1'b1;
    rd_en  = 1'b1;
    @(negedge clk);
    rd_en  = 1'b0;
    bus_en = 1'b0;
    check("sim_ack", nibble_ack, 1);
    check("sim_count", count, DEPTH);
    @(negedge clk);
    check("sim_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) pop_check();
    check("sim_drained", rd_valid, 0);

    // Reset in the middle of a byte discards the low nibble.
    send_nibble(4'h7, 1);
    do_reset();
    check("mid_rst_count", count, 0);
    mq.push_back(8'h21);
    send_nibble(4'h1, 1);
    send_nibble(4'h2, 1);
    check("mid_rst_data", rd_data, 8'h21);
    check("mid_rst_cnt1", count, 1);

`ifdef RX_TIMEOUT_EN
    do_reset();
    send_nibble(4'hE, 1);
    tick(20);
    check("tmo_err", timeout_err, 1);
    check("tmo_count", count, 0);
    mq.push_back(8'hDC);
    send_nibble(4'hC, 1);
    send_nibble(4'hD, 1);
    check("tmo_data", rd_data, 8'hDC);
    check("tmo_cnt1", count, 1);
`else
    check("no_tmo_err", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
